// File: rtl/apb_defs.sv
// rtl/apb_defs.sv - shared APB state encodings, bus widths and error causes
package apb_defs;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SLVERR  = 2'd1,
    ERR_ALIGN   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } apb_err_e;

  // Returns {err, timeout} as reported on the response channel.
  function automatic logic [1:0] err_flags(apb_err_e cause);
    return {cause != ERR_NONE, cause == ERR_TIMEOUT};
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// rtl/apb_timeout_ctr.sv - saturating ACCESS-cycle counter flagging the last allowed cycle
module apb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && count_q != LIMIT) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High during the ACCESS cycle that would push the count to TIMEOUT_CYCLES.
  assign expire_o = en_i && (count_q == LIMIT_M1);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB3 initiator with alignment check and PREADY watchdog
module apb_master_bridge
  import apb_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              apb_psel_o,
  output logic              apb_penable_o,
  output logic              apb_pwrite_o,
  output logic [ADDR_W-1:0] apb_paddr_o,
  output logic [DATA_W-1:0] apb_pwdata_o,
  input  logic [DATA_W-1:0] apb_prdata_i,
  input  logic              apb_pready_i,
  input  logic              apb_pslverr_i
);

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic ctr_clr, ctr_en, ctr_expire;

  apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expire_o (ctr_expire)
  );

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          pwrite_d    = cmd_write_i;
          paddr_d     = cmd_addr_i;
          pwdata_d    = cmd_wdata_i;
          cmd_ready_d = 1'b0;
          if (cmd_addr_i[1:0] != 2'b00) begin
            // Misaligned: answer directly, the bus never sees this command.
            state_d                    = ST_RESP;
            rsp_valid_d                = 1'b1;
            rsp_rdata_d                = '0;
            {rsp_err_d, rsp_timeout_d} = err_flags(ERR_ALIGN);
          end else begin
            state_d   = ST_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            ctr_clr   = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        ctr_en = 1'b1;
        if (apb_pready_i || ctr_expire) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end
        // A late PREADY still wins over the watchdog in its final cycle.
        if (apb_pready_i) begin
          rsp_rdata_d = pwrite_q ? '0 : apb_prdata_i;
          {rsp_err_d, rsp_timeout_d} = err_flags(apb_pslverr_i ? ERR_SLVERR : ERR_NONE);
        end else if (ctr_expire) begin
          rsp_rdata_d = '0;
          {rsp_err_d, rsp_timeout_d} = err_flags(ERR_TIMEOUT);
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;
  logic        apb_psel_o, apb_penable_o, apb_pwrite_o;
  logic [31:0] apb_paddr_o, apb_pwdata_o, apb_prdata_i;
  logic        apb_pready_i, apb_pslverr_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  apb_master_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk_i         (clk_i),
    .resetn_i      (resetn_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_write_i   (cmd_write_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .apb_psel_o    (apb_psel_o),
    .apb_penable_o (apb_penable_o),
    .apb_pwrite_o  (apb_pwrite_o),
    .apb_paddr_o   (apb_paddr_o),
    .apb_pwdata_o  (apb_pwdata_o),
    .apb_prdata_i  (apb_prdata_i),
    .apb_pready_i  (apb_pready_i),
    .apb_pslverr_i (apb_pslverr_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave inserts wt wait states: PREADY is high in ACCESS cycle wt+1.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int wt, input logic slverr, input logic [31:0] prdata,
                         input int rdly);
    logic        mis;
    int          exp_acc, exp_lat, exp_setup;
    logic        exp_err, exp_to;
    logic [31:0] exp_rdata;
    int          cyc, lat, setup, acc, bad, busy_rdy, held_bad;
    logic [31:0] r0;
    logic        e0, t0;

    mis = (addr[1:0] != 2'b00);
    if (mis) begin
      exp_acc = 0; exp_err = 1'b1; exp_to = 1'b0; exp_rdata = '0; exp_lat = 1; exp_setup = 0;
    end else begin
      exp_setup = 1;
      if (wt + 1 > TO) begin
        exp_acc = TO; exp_err = 1'b1; exp_to = 1'b1; exp_rdata = '0;
      end else begin
        exp_acc = wt + 1; exp_err = slverr; exp_to = 1'b0; exp_rdata = wr ? 32'h0 : prdata;
      end
      exp_lat = 2 + exp_acc;
    end

    check("idle_cmd_ready", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata;
    cyc = 0; lat = -1; setup = 0; acc = 0; bad = 0; busy_rdy = 0;
    while (lat < 0 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) begin
        cmd_valid_i = 1'b0; cmd_write_i = $urandom; cmd_addr_i = $urandom; cmd_wdata_i = $urandom;
      end
      if (cmd_ready_o) busy_rdy++;
      if (apb_psel_o) begin
        if (apb_paddr_o !== addr || apb_pwrite_o !== wr || apb_pwdata_o !== wdata) bad++;
        if (apb_penable_o) acc++; else setup++;
      end else if (apb_penable_o) begin
        bad++;
      end
      if (apb_psel_o && apb_penable_o && acc == wt + 1) begin
        apb_pready_i = 1'b1; apb_pslverr_i = slverr; apb_prdata_i = prdata;
      end else begin
        apb_pready_i = 1'b0; apb_pslverr_i = $urandom; apb_prdata_i = $urandom;
      end
      if (rsp_valid_o) lat = cyc;
    end
    apb_pready_i = 1'b0;

    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("setup_cycles", 64'(setup), 64'(exp_setup));
    check("access_cycles", 64'(acc), 64'(exp_acc));
    check("bus_stable", 64'(bad), 64'd0);
    check("rsp_rdata", rsp_rdata_o, exp_rdata);
    check("rsp_err", rsp_err_o, exp_err);
    check("rsp_timeout", rsp_timeout_o, exp_to);

    r0 = rsp_rdata_o; e0 = rsp_err_o; t0 = rsp_timeout_o; held_bad = 0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== r0 || rsp_err_o !== e0 ||
          rsp_timeout_o !== t0 || apb_psel_o !== 1'b0) held_bad++;
      if (cmd_ready_o) busy_rdy++;
    end
    check("rsp_held", 64'(held_bad), 64'd0);
    check("busy_cmd_ready", 64'(busy_rdy), 64'd0);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("rsp_drop", rsp_valid_o, 1'b0);
    check("ready_back", cmd_ready_o, 1'b1);
  endtask

  initial begin
    int guard;
    logic [31:0] a;
    resetn_i = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b0; apb_prdata_i = '0; apb_pready_i = 1'b0; apb_pslverr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_psel", apb_psel_o, 1'b0);
    check("rst_penable", apb_penable_o, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_rsp_err", {rsp_err_o, rsp_timeout_o, rsp_rdata_o}, 34'h0);
    resetn_i = 1'b1;
    @(negedge clk_i);

    run_txn(1'b1, 32'h0000_0008, 32'hA5A5_1234, 1, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h0000_0008, 32'h0, 0, 1'b0, 32'hA5A5_1234, 3);
    run_txn(1'b0, 32'h0000_0041, 32'h0, 0, 1'b0, 32'h1111_2222, 1);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 1000, 1'b0, 32'h3333_4444, 0);
    run_txn(1'b0, 32'h0000_0014, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 2);
    run_txn(1'b0, 32'h0000_0018, 32'h0, TO - 1, 1'b0, 32'h5555_6666, 0);
    run_txn(1'b1, 32'h0000_001C, 32'h7777_8888, TO, 1'b0, 32'h0, 1);

    // Reset during ACCESS with a slave that never answers.
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h20; cmd_wdata_i = '0;
    guard = 0;
    do begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      guard++;
    end while (!(apb_psel_o && apb_penable_o) && guard < 20);
    check("reach_access", apb_penable_o, 1'b1);
    #2 resetn_i = 1'b0;
    #1;
    check("async_psel", apb_psel_o, 1'b0);
    check("async_penable", apb_penable_o, 1'b0);
    check("async_rsp_valid", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    resetn_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_ready", cmd_ready_o, 1'b1);
    check("post_rst_rsp", rsp_valid_o, 1'b0);
    run_txn(1'b0, 32'h0000_0024, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn(1'($urandom), a, $urandom, $urandom_range(0, 6), 1'($urandom), $urandom,
              $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
